vga_pattern_ctrl: RTL

//  Controller for the VGA test-pattern generator's 2-bit pattern select.

---
 rtl/vga_pkg.sv | 17 +
 rtl/key_debounce.sv | 59 +++++
 rtl/vga_pattern_ctrl.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared pattern-select encoding for the VGA test-pattern path.
// Mode values are what the pattern datapath decodes.
package vga_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HBARS = 2'd0;
    localparam logic [MODE_W-1:0] MODE_VBARS = 2'd1;
    localparam logic [MODE_W-1:0] MODE_XOR   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_XNOR  = 2'd3;

    // Next pattern in sequence; wraps XNOR back to HBARS.
    function automatic logic [MODE_W-1:0] mode_inc(input logic [MODE_W-1:0] m);
        return m + MODE_W'(1);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Active-low key debouncer: 2-FF synchronizer plus stability counter.
// Press pulse is registered and fires once, on the same edge the stable level falls.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_d;
    logic             press_q;
    logic             press_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        press_d  = 1'b0;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stable_d = sync2_q;
            cnt_d    = '0;
            // Level differs from stable, so stable_q=1 means this is a 1->0 fall.
            press_d  = stable_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Idle-high reset levels: a key held through reset release must re-debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            stable_q <= 1'b1;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// Pattern-select controller: key0 advances the mode, key1 toggles auto-cycle.
// Mode changes are staged in pending_mode and only applied on frame_start edges.
module vga_pattern_ctrl
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int FRAMES_PER_MODE = 120
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        key,
    input  logic              frame_start,
    output logic [MODE_W-1:0] mode,
    output logic              auto_en,
    output logic              mode_changed
);

    localparam int FC_W = $clog2(FRAMES_PER_MODE + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAMES_PER_MODE - 1);

    logic              press0;
    logic              press1;
    logic              auto_adv;

    logic [MODE_W-1:0] pending_q;
    logic [MODE_W-1:0] pending_d;
    logic [MODE_W-1:0] mode_q;
    logic [MODE_W-1:0] mode_d;
    logic [FC_W-1:0]   frame_cnt_q;
    logic [FC_W-1:0]   frame_cnt_d;
    logic              auto_en_q;
    logic              auto_en_d;
    logic              changed_q;
    logic              changed_d;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key[0]),
        .press (press0)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key[1]),
        .press (press1)
    );

    assign auto_adv = auto_en_q && frame_start && (frame_cnt_q == FC_LAST);

    always_comb begin
        pending_d   = pending_q;
        frame_cnt_d = frame_cnt_q;
        auto_en_d   = auto_en_q;
        mode_d      = mode_q;
        changed_d   = 1'b0;

        // A manual press and an auto advance on the same edge count once.
        if (press0 || auto_adv) begin
            pending_d = mode_inc(pending_q);
        end

        if (!auto_en_q || press0 || press1) begin
            frame_cnt_d = '0;
        end else if (frame_start) begin
            frame_cnt_d = auto_adv ? '0 : frame_cnt_q + FC_W'(1);
        end

        if (press1) begin
            auto_en_d = !auto_en_q;
        end

        // Apply the post-advance pending value so same-edge advances land this frame.
        if (frame_start) begin
            mode_d    = pending_d;
            changed_d = (pending_d != mode_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= MODE_HBARS;
            mode_q      <= MODE_HBARS;
            frame_cnt_q <= '0;
            auto_en_q   <= 1'b0;
            changed_q   <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            mode_q      <= mode_d;
            frame_cnt_q <= frame_cnt_d;
            auto_en_q   <= auto_en_d;
            changed_q   <= changed_d;
        end
    end

    assign mode         = mode_q;
    assign auto_en      = auto_en_q;
    assign mode_changed = changed_q;

endmodule
